// File: rtl/bp_mem_latency_model.sv
//==============================================================================
// Module   : bp_mem_latency_model
// Brief    : Fixed-latency, block-granular memory model for the CCE memory ports.
//            Optional counters/check enabled by BP_MEM_LATENCY_MODEL_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bp_mem_latency_model #(
  parameter int num_lce_p             = 2,
  parameter int lce_assoc_p           = 8,
  parameter int addr_width_p          = 22,
  parameter int block_size_in_bytes_p = 64,
  parameter int mem_els_p             = 512,
  parameter int latency_p             = 4,

  localparam int block_size_in_bits_lp = block_size_in_bytes_p * 8,
  localparam int c_lce_id_w   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int c_way_w      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int c_payload_w  = c_lce_id_w + c_way_w,
  // Message header, MSB first: {msg_type, addr, payload={lce_id, way_id}, non_cacheable}
  localparam int c_hdr_w      = 1 + addr_width_p + c_payload_w + 1,
  localparam int bp_cce_mem_cmd_width_lp      = c_hdr_w,
  localparam int bp_cce_mem_data_cmd_width_lp = c_hdr_w + block_size_in_bits_lp,
  localparam int bp_mem_cce_resp_width_lp     = c_hdr_w,
  localparam int bp_mem_cce_data_resp_width_lp = c_hdr_w + block_size_in_bits_lp
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [bp_cce_mem_cmd_width_lp-1:0]       mem_cmd_i,
  input  logic                                     mem_cmd_v_i,
  output logic                                     mem_cmd_yumi_o,
  input  logic [bp_cce_mem_data_cmd_width_lp-1:0]  mem_data_cmd_i,
  input  logic                                     mem_data_cmd_v_i,
  output logic                                     mem_data_cmd_yumi_o,
  output logic [bp_mem_cce_resp_width_lp-1:0]      mem_resp_o,
  output logic                                     mem_resp_v_o,
  input  logic                                     mem_resp_ready_i,
  output logic [bp_mem_cce_data_resp_width_lp-1:0] mem_data_resp_o,
  output logic                                     mem_data_resp_v_o,
  input  logic                                     mem_data_resp_ready_i
`ifdef BP_MEM_LATENCY_MODEL_STATS_EN
  ,output logic [95:0]                             stats_o
`endif
);

  localparam int         c_off_w   = $clog2(block_size_in_bytes_p);
  localparam int         c_idx_w   = $clog2(mem_els_p);
  localparam int         c_addr_lsb = 1 + c_payload_w;
  localparam logic [7:0] c_latency = 8'(latency_p);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                             r_state;
  state_e                             w_state_next;
  logic [7:0]                         r_count;
  logic                               r_is_wr;
  logic [c_hdr_w-1:0]                 r_hdr;
  logic [block_size_in_bits_lp-1:0]   r_data;
  logic                               r_resp_v;
  logic                               r_data_resp_v;
  logic                               w_accept_wr;
  logic                               w_accept_rd;
  logic                               w_handshake;
  logic [c_idx_w-1:0]                 w_wr_index;
  logic [c_idx_w-1:0]                 w_rd_index;
  logic [block_size_in_bits_lp-1:0]   r_mem [mem_els_p];

  // Offset bits below the block and address bits above the index are dropped.
  assign w_wr_index  = mem_data_cmd_i[block_size_in_bits_lp + c_addr_lsb + c_off_w +: c_idx_w];
  assign w_rd_index  = mem_cmd_i[c_addr_lsb + c_off_w +: c_idx_w];
  assign w_handshake = (r_resp_v & mem_resp_ready_i) | (r_data_resp_v & mem_data_resp_ready_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept_wr  = 1'b0;
    w_accept_rd  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Writebacks win so they are ordered ahead of a racing refill.
        if (!reset_i) begin
          if (mem_data_cmd_v_i) begin
            w_accept_wr = 1'b1;
          end else if (mem_cmd_v_i) begin
            w_accept_rd = 1'b1;
          end
        end
        if (w_accept_wr || w_accept_rd) begin
          w_state_next = (c_latency == 8'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_count == 8'd0) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_handshake) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign mem_data_cmd_yumi_o = w_accept_wr;
  assign mem_cmd_yumi_o      = w_accept_rd;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count       <= 8'd0;
      r_is_wr       <= 1'b0;
      r_hdr         <= '0;
      r_data        <= '0;
      r_resp_v      <= 1'b0;
      r_data_resp_v <= 1'b0;
    end else begin
      if (w_accept_wr) begin
        r_is_wr <= 1'b1;
        r_hdr   <= mem_data_cmd_i[bp_cce_mem_data_cmd_width_lp-1 -: c_hdr_w];
      end else if (w_accept_rd) begin
        r_is_wr <= 1'b0;
        r_hdr   <= mem_cmd_i;
        r_data  <= r_mem[w_rd_index];
      end

      if (w_accept_wr || w_accept_rd) begin
        r_count <= (c_latency == 8'd0) ? 8'd0 : c_latency - 8'd1;
      end else if (r_state == ST_WAIT && r_count != 8'd0) begin
        r_count <= r_count - 8'd1;
      end

      // With zero latency the type is taken from the accept itself, not from r_is_wr.
      if (w_state_next == ST_RESP && r_state != ST_RESP) begin
        r_resp_v      <= (r_state == ST_IDLE) ? w_accept_wr : r_is_wr;
        r_data_resp_v <= (r_state == ST_IDLE) ? w_accept_rd : !r_is_wr;
      end else if (w_handshake) begin
        r_resp_v      <= 1'b0;
        r_data_resp_v <= 1'b0;
      end
    end
  end

  // Storage has no reset so its contents survive a reset of the control path.
  always_ff @(posedge clk_i) begin
    if (w_accept_wr) begin
      r_mem[w_wr_index] <= mem_data_cmd_i[block_size_in_bits_lp-1:0];
    end
  end

  assign mem_resp_o        = r_hdr;
  assign mem_resp_v_o      = r_resp_v;
  assign mem_data_resp_o   = {r_hdr, r_data};
  assign mem_data_resp_v_o = r_data_resp_v;

`ifdef BP_MEM_LATENCY_MODEL_STATS_EN
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_bp;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_stat_rd <= 32'd0;
      r_stat_wr <= 32'd0;
      r_stat_bp <= 32'd0;
    end else begin
      if (w_accept_rd && r_stat_rd != 32'hFFFF_FFFF) r_stat_rd <= r_stat_rd + 32'd1;
      if (w_accept_wr && r_stat_wr != 32'hFFFF_FFFF) r_stat_wr <= r_stat_wr + 32'd1;
      if (((r_resp_v && !mem_resp_ready_i) || (r_data_resp_v && !mem_data_resp_ready_i))
          && r_stat_bp != 32'hFFFF_FFFF) begin
        r_stat_bp <= r_stat_bp + 32'd1;
      end
    end
  end

  assign stats_o = {r_stat_bp, r_stat_wr, r_stat_rd};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(r_resp_v && r_data_resp_v))
        else $error("bp_mem_latency_model: both response valids asserted");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_mem_latency_model.sv
//==============================================================================
// Module   : tb_bp_mem_latency_model
// Brief    : Randomized scoreboard bench; DUT 0 uses latency 4, DUT 1 latency 0.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bp_mem_latency_model;
  localparam int AW     = 22;
  localparam int BBYTES = 64;
  localparam int BBITS  = BBYTES * 8;
  localparam int ELS    = 512;
  localparam int HW     = 1 + AW + 4 + 1;
  localparam int DW     = HW + BBITS;
  localparam int SW     = DW + 2;

  typedef logic [HW-1:0]    hdr_t;
  typedef logic [BBITS-1:0] blk_t;
  typedef struct {
    bit     is_wr;
    hdr_t   hdr;
    blk_t   data;
    bit     chk_data;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst       [2];
  logic [HW-1:0] cmd       [2];
  logic          cmd_v     [2];
  logic          cmd_yumi  [2];
  logic [DW-1:0] dcmd      [2];
  logic          dcmd_v    [2];
  logic          dcmd_yumi [2];
  logic [HW-1:0] resp      [2];
  logic          resp_v    [2];
  logic          resp_rdy  [2];
  logic [DW-1:0] dresp     [2];
  logic          dresp_v   [2];
  logic          dresp_rdy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bp_mem_latency_model #(
      .num_lce_p(2), .lce_assoc_p(8), .addr_width_p(AW),
      .block_size_in_bytes_p(BBYTES), .mem_els_p(ELS), .latency_p(g == 0 ? 4 : 0)
    ) u_dut (
      .clk_i(clk), .reset_i(rst[g]),
      .mem_cmd_i(cmd[g]), .mem_cmd_v_i(cmd_v[g]), .mem_cmd_yumi_o(cmd_yumi[g]),
      .mem_data_cmd_i(dcmd[g]), .mem_data_cmd_v_i(dcmd_v[g]), .mem_data_cmd_yumi_o(dcmd_yumi[g]),
      .mem_resp_o(resp[g]), .mem_resp_v_o(resp_v[g]), .mem_resp_ready_i(resp_rdy[g]),
      .mem_data_resp_o(dresp[g]), .mem_data_resp_v_o(dresp_v[g]), .mem_data_resp_ready_i(dresp_rdy[g])
    );
  end

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          q0[$];
  exp_t          q1[$];
  blk_t          mm [2][ELS];
  bit            mv [2][ELS];
  bit            held [2];
  logic [SW-1:0] snap [2];
  int            bp_hold [2];
  bit            force_rdy [2];
  longint        last_acc [2];

  function automatic int lat(int d);
    return (d == 0) ? 4 : 0;
  endfunction

  // Block index from plain address arithmetic: drop the byte offset, wrap modulo depth.
  function automatic int idx_of(hdr_t h);
    logic [AW-1:0] a;
    a = h[HW-2 -: AW];
    return (int'(a) / BBYTES) % ELS;
  endfunction

  function automatic hdr_t mk_hdr(logic [AW-1:0] a);
    return {1'($urandom_range(1)), a, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1))};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(127) * 32768 + $urandom_range(15) * 64 + $urandom_range(63));
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic void qpush(int d, exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic exp_t qpop(int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk_v(string name, logic [SW-1:0] act, logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bad(string name, int d);
    n_cmp++;
    n_err++;
    $display("FAIL %s: dut %0d at cycle %0d", name, d, cyc);
  endtask

  // Present a write and/or a read; push the expected response at the moment of acceptance.
  task automatic drive(int d, bit wr_en, hdr_t whdr, blk_t wdata, bit rd_en, hdr_t rhdr);
    bit   wp;
    bit   rp;
    int   budget;
    int   i;
    exp_t e;
    wp = wr_en;
    rp = rd_en;
    budget = 400;
    dcmd[d] = {whdr, wdata};
    dcmd_v[d] = wr_en;
    cmd[d] = rhdr;
    cmd_v[d] = rd_en;
    while ((wp || rp) && budget > 0) begin
      #1;
      if (dcmd_yumi[d]) begin
        if (!wp) begin
          bad("unexpected_wr_yumi", d);
        end else begin
          if (rp) chk_i("wr_priority_rd_yumi", longint'(cmd_yumi[d]), 0);
          i = idx_of(whdr);
          mm[d][i] = wdata;
          mv[d][i] = 1'b1;
          e.is_wr = 1'b1; e.hdr = whdr; e.data = wdata; e.chk_data = 1'b0; e.acc = cyc;
          qpush(d, e);
          last_acc[d] = cyc;
          wp = 1'b0;
        end
      end else if (cmd_yumi[d]) begin
        if (!rp || wp) begin
          bad("unexpected_rd_yumi", d);
        end else begin
          i = idx_of(rhdr);
          e.is_wr = 1'b0; e.hdr = rhdr; e.data = mm[d][i]; e.chk_data = mv[d][i]; e.acc = cyc;
          qpush(d, e);
          last_acc[d] = cyc;
          rp = 1'b0;
        end
      end
      @(negedge clk);
      dcmd_v[d] = wp;
      cmd_v[d] = rp;
      budget--;
    end
    if (wp || rp) begin
      bad("accept_timeout", d);
      dcmd_v[d] = 1'b0;
      cmd_v[d] = 1'b0;
    end
  endtask

  task automatic monitor(int d);
    logic [SW-1:0] cur;
    hdr_t          act_hdr;
    exp_t          e;
    bit            rdy;
    forever begin
      @(negedge clk);
      if (rst[d]) begin
        held[d] = 1'b0;
        resp_rdy[d] = 1'b0;
        dresp_rdy[d] = 1'b0;
        continue;
      end
      if (resp_v[d] || dresp_v[d]) begin
        chk_i("single_valid", longint'(resp_v[d] & dresp_v[d]), 0);
        chk_i("no_yumi_in_resp", longint'(cmd_yumi[d] | dcmd_yumi[d]), 0);
        cur = {resp_v[d], dresp_v[d], resp_v[d] ? {resp[d], {BBITS{1'b0}}} : dresp[d]};
        if (!held[d]) begin
          if (qsize(d) == 0) begin
            bad("spurious_resp", d);
          end else begin
            e = qpop(d);
            act_hdr = resp_v[d] ? resp[d] : dresp[d][DW-1 -: HW];
            chk_i("resp_kind", longint'(resp_v[d]), longint'(e.is_wr));
            chk_v("resp_fields", SW'(act_hdr), SW'(e.hdr));
            if (!e.is_wr && e.chk_data) chk_v("resp_data", SW'(dresp[d][BBITS-1:0]), SW'(e.data));
            chk_i("resp_latency", cyc - e.acc, longint'(lat(d) + 1));
          end
          held[d] = 1'b1;
          snap[d] = cur;
        end else begin
          chk_v("resp_stable", cur, snap[d]);
        end
        if (bp_hold[d] > 0) begin
          rdy = 1'b0;
          bp_hold[d]--;
        end else begin
          rdy = force_rdy[d] || ($urandom_range(3) != 0);
        end
        if (rdy) held[d] = 1'b0;
        resp_rdy[d] = rdy;
        dresp_rdy[d] = rdy;
      end else begin
        if (held[d]) begin
          bad("resp_dropped_before_ready", d);
          held[d] = 1'b0;
        end
        resp_rdy[d] = 1'($urandom_range(1));
        dresp_rdy[d] = 1'($urandom_range(1));
      end
    end
  endtask

  task automatic wait_idle(int d);
    int budget;
    budget = 500;
    while ((qsize(d) != 0 || held[d]) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (qsize(d) != 0 || held[d]) bad("idle_timeout", d);
  endtask

  task automatic rand_traffic(int d, int n);
    int   op;
    hdr_t h1;
    hdr_t h2;
    blk_t dat;
    for (int k = 0; k < n; k++) begin
      op  = $urandom_range(2);
      dat = rnd_blk();
      h1  = mk_hdr(rnd_addr());
      h2  = mk_hdr(rnd_addr());
      drive(d, op != 1, h1, dat, op != 0, h2);
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t   dat;
    longint prev;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cmd[d] = '0; cmd_v[d] = 1'b1; dcmd[d] = '0; dcmd_v[d] = 1'b1;
      resp_rdy[d] = 1'b0; dresp_rdy[d] = 1'b0;
      held[d] = 1'b0; bp_hold[d] = 0; force_rdy[d] = 1'b0; last_acc[d] = 0;
      for (int i = 0; i < ELS; i++) mv[d][i] = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset with both command valids raised: nothing may be consumed or returned.
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk_i("reset_yumi", longint'(cmd_yumi[d] | dcmd_yumi[d]), 0);
        chk_i("reset_valid", longint'(resp_v[d] | dresp_v[d]), 0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmd_v[d] = 1'b0; dcmd_v[d] = 1'b0; rst[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_v("reset_resp_regs", SW'({resp[d], dresp[d]}), SW'(0));
    end

    // Write block 0x40 with the A5 pattern, then read it back.
    dat = {64{8'hA5}};
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, mk_hdr(22'h40), dat, 1'b0, '0);
      drive(d, 1'b0, '0, '0, 1'b1, mk_hdr(22'h40));
      wait_idle(d);
    end

    // Racing write and read to the same block: write first, read returns new data.
    dat = rnd_blk();
    drive(0, 1'b1, mk_hdr(22'h1C0), dat, 1'b1, mk_hdr(22'h1FF));
    wait_idle(0);

    // Ten cycles of backpressure on a read response.
    force_rdy[0] = 1'b1;
    bp_hold[0] = 10;
    drive(0, 1'b0, '0, '0, 1'b1, mk_hdr(22'h40));
    wait_idle(0);
    chk_i("backpressure_cycles_used", longint'(bp_hold[0]), 0);
    force_rdy[0] = 1'b0;

    // Aliasing: 0x8000 wraps onto block 0.
    for (int d = 0; d < 2; d++) begin
      dat = rnd_blk();
      drive(d, 1'b1, mk_hdr(22'h0), dat, 1'b0, '0);
      drive(d, 1'b0, '0, '0, 1'b1, mk_hdr(22'h8000));
      wait_idle(d);
    end

    // Zero latency with ready held: one accept every two cycles.
    force_rdy[1] = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b0, '0, '0, 1'b1, mk_hdr(rnd_addr()));
      if (k > 0) chk_i("zero_latency_accept_spacing", last_acc[1] - prev, 2);
      prev = last_acc[1];
    end
    wait_idle(1);
    force_rdy[1] = 1'b0;

    fork
      rand_traffic(0, 120);
      rand_traffic(1, 120);
    join
    wait_idle(0);
    wait_idle(1);

    // Reset two cycles after a read accept: the response is dropped, storage kept.
    drive(0, 1'b0, '0, '0, 1'b1, mk_hdr(22'h40));
    @(negedge clk);
    rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    rst[0] = 1'b0;
    chk_i("mid_reset_valid", longint'(resp_v[0] | dresp_v[0]), 0);
    chk_v("mid_reset_resp_regs", SW'({resp[0], dresp[0]}), SW'(0));
    repeat (10) @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b1, mk_hdr(22'h40));
    wait_idle(0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_mem_latency_model.md
Name: bp_mem_latency_model

Overview:
- Single-port, block-granular memory model that sits directly downstream of the CCE's outbound memory FIFOs.
- Consumes CCE memory commands (mem_cmd, mem_data_cmd) with valid->yumi handshakes.
- Services each command after a programmable fixed latency.
- Returns mem_resp (writes) or mem_data_resp (reads) to the CCE's inbound memory FIFOs with ready->valid handshakes.
- Used in CCE unit testbenches and single-core simulation tops in place of a DRAM controller.

Parameters:
- num_lce_p, "inv", LCE count; sizes the message structs.
- lce_assoc_p, "inv", LCE associativity; sizes the message structs.
- addr_width_p, "inv", physical address width.
- block_size_in_bytes_p, "inv", cache block size; one storage entry per block.
- mem_els_p, 512, number of blocks stored; must be a power of 2, ≥2.
- latency_p, 4, cycles between command accept and response valid; 0..255.
- Derived: block_size_in_bits_lp = block_size_in_bytes_p*8; struct widths via the standard bp_cce_mem_* / bp_mem_cce_* width macros.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_cmd_i  in  bp_cce_mem_cmd_width_lp  read command.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_yumi_o  out  1  command consumed this cycle.
- mem_data_cmd_i  in  bp_cce_mem_data_cmd_width_lp  write command with data.
- mem_data_cmd_v_i  in  1  write command valid.
- mem_data_cmd_yumi_o  out  1  write command consumed this cycle.
- mem_resp_o  out  bp_mem_cce_resp_width_lp  write acknowledge.
- mem_resp_v_o  out  1  acknowledge valid.
- mem_resp_ready_i  in  1  consumer ready.
- mem_data_resp_o  out  bp_mem_cce_data_resp_width_lp  read data response.
- mem_data_resp_v_o  out  1  read response valid.
- mem_data_resp_ready_i  in  1  consumer ready.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Both yumi outputs and both response valid outputs are 0 during and after reset.
  - FSM goes to IDLE; latency counter is 0.
  - Response registers are 0.
  - Storage is NOT cleared by reset; contents survive reset.
- FSM states:
  - IDLE: accepts at most one command per cycle.
    - If mem_data_cmd_v_i=1, assert mem_data_cmd_yumi_o combinationally in the same cycle. This path has priority so a writeback is ordered before a racing refill.
    - Else if mem_cmd_v_i=1, assert mem_cmd_yumi_o.
    - On accept: capture msg_type, addr, payload and non_cacheable into the response register. For writes, write data to storage in the accept cycle.
    - Go to WAIT if latency_p>0; else go to RESP.
  - WAIT: counter runs from latency_p-1 down to 0; at 0 go to RESP. Yumis are 0.
  - RESP:
    - Assert exactly one of mem_resp_v_o (write) or mem_data_resp_v_o (read), registered.
    - Hold the valid and all output fields stable until the matching ready_i is sampled 1.
    - Return to IDLE on the following edge.
    - A new command may be accepted in the cycle after the response handshake, never in the same cycle.
- Latency: accept at edge N → response valid from edge N+latency_p+1; with latency_p=0, valid from edge N+1.
- Read response data is storage[index] as read at the accept cycle, so a read sees all earlier accepted writes.
- Address mapping:
  - index = addr[log2(block_size_in_bytes_p) +: log2(mem_els_p)].
  - Upper address bits are ignored (aliasing wrap-around).
  - Sub-block offset bits are ignored.
- Response fields: msg_type, addr, payload and non_cacheable are copied unchanged from the command. Payload carries the LCE id and way back to the CCE.
- Ready is ignored outside RESP; the block never issues a response without a prior accept.
- Reset mid-operation drops any in-flight response. A write that was already accepted has updated storage.

Optional Feature:
- Macro: BP_MEM_LATENCY_MODEL_STATS_EN.
- When defined, adds:
  - 32-bit read and write accept counters (saturating, reset to 0).
  - A 32-bit cycle counter of RESP-state backpressure (valid=1 and ready=0).
  - All three are exposed on an output port stats_o (96 bits: {backpressure, writes, reads}).
  - An $error fires if both response valids are ever high together.
- When undefined: no counters, no stats_o port, no assertions; the functional behaviour above is identical.

Test Plan:
- Write then read: latency_p=4; write block 0x40 with data D=0xA5 repeated; then read addr 0x40 → mem_resp_v_o 5 cycles after the write accept; mem_data_resp_v_o 5 cycles after the read accept; data=D; payload echoed.
- Simultaneous commands: mem_cmd_v_i and mem_data_cmd_v_i both 1 in IDLE → mem_data_cmd_yumi_o=1 and mem_cmd_yumi_o=0 that cycle; the read is accepted in the cycle after the write response handshake and returns the new data.
- Backpressure: hold mem_data_resp_ready_i=0 for 10 cycles in RESP → valid and data stable for all 10 cycles; no yumi asserted; handshake and return to IDLE on ready=1.
- Aliasing: mem_els_p=512, 64B blocks; write addr 0x0, then read addr 0x8000 (index wraps to 0) → returns the written data.
- Zero latency: latency_p=0 → response valid 1 cycle after accept; back-to-back reads sustain 1 transaction per 2 cycles with ready held 1.
- Reset in WAIT: assert reset_i 2 cycles after a read accept → no response ever appears; outputs 0; the next command is serviced normally and storage is intact.
